chien_search_serial: RTL and testbench

//  Chien search stage fed by the serial Berlekamp-Massey decoder. Latches the final

---
 rtl/chien_search_serial.sv | 163 ++++++++++++++++
 tb/tb_chien_search_serial.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/chien_search_serial.sv
// Serial Chien search: steps the error-locator sigma(x) over all N=2^M-1 positions, one per clock.
// Optional root counter / failure flag enabled with CHIEN_ERRCNT_EN.
module chien_search_serial #(
  parameter int M = 4,
  parameter int T = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [M*(T+1)-1:0] sigma_i,
  input  logic             sigma_valid_i,
  output logic             ready_o,
  output logic             err_o,
  output logic             err_valid_o,
  output logic             err_first_o,
  output logic             err_last_o,
  output logic [M-1:0]     err_count_o,
  output logic             fail_o
);

  localparam int N = (1 << M) - 1;

  function automatic int prim_poly(input int m);
    case (m)
      3:       return 'b1011;
      5:       return 'b100101;
      6:       return 'b1000011;
      7:       return 'b10001001;
      8:       return 'b100011101;
      9:       return 'b1000010001;
      10:      return 'b10000001001;
      default: return 'b10011;
    endcase
  endfunction

  localparam int           PRIM_INT = prim_poly(M);
  localparam logic [M-1:0] PRIM_LO  = PRIM_INT[M-1:0];
  localparam logic [M-1:0] LAST_CNT = M'(N - 1);

  function automatic logic [M-1:0] mul_alpha(input logic [M-1:0] v);
    return v[M-1] ? ({v[M-2:0], 1'b0} ^ PRIM_LO) : {v[M-2:0], 1'b0};
  endfunction

  function automatic logic [M-1:0] mul_alpha_pow(input logic [M-1:0] v, input int p);
    logic [M-1:0] r;
    r = v;
    for (int j = 0; j < p; j++) r = mul_alpha(r);
    return r;
  endfunction

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state_q;
  logic [M-1:0] cnt_q;
  logic         ready_q, err_q, err_valid_q, err_first_q, err_last_q;
  logic [M-1:0] reg_q [1:T];
  logic [M-1:0] reg_d [1:T];
  logic         accept;
  logic         e;
  logic         unused_sigma0;

  // sigma_0 is assumed to be 1 and never read.
  assign unused_sigma0 = ^sigma_i[M-1:0];
  assign accept        = sigma_valid_i && ready_q;

  for (genvar gi = 1; gi <= T; gi++) begin : g_term
    assign reg_d[gi] = accept ? mul_alpha_pow(sigma_i[M*gi +: M], gi)
                              : mul_alpha_pow(reg_q[gi], gi);
  end

  always_ff @(posedge clk_i) begin
    for (int i = 1; i <= T; i++) begin
      if (reset_i)                      reg_q[i] <= '0;
      else if (accept || state_q == RUN) reg_q[i] <= reg_d[i];
    end
  end

  // Root test at the current step: 1 ^ sum(reg_i) == 0.
  always_comb begin
    logic [M-1:0] acc;
    acc = {{(M-1){1'b0}}, 1'b1};
    for (int i = 1; i <= T; i++) acc = acc ^ reg_q[i];
    e = ~|acc;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      err_valid_q <= 1'b0;
      err_first_q <= 1'b0;
      err_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          err_q       <= 1'b0;
          err_valid_q <= 1'b0;
          err_first_q <= 1'b0;
          err_last_q  <= 1'b0;
          if (sigma_valid_i) begin
            state_q <= RUN;
            ready_q <= 1'b0;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          err_q       <= e;
          err_valid_q <= 1'b1;
          err_first_q <= (cnt_q == '0);
          err_last_q  <= (cnt_q == LAST_CNT);
          cnt_q       <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o     = ready_q;
  assign err_o       = err_q;
  assign err_valid_o = err_valid_q;
  assign err_first_o = err_first_q;
  assign err_last_o  = err_last_q;

`ifdef CHIEN_ERRCNT_EN
  logic [M-1:0] deg_d, deg_q, cnt_err_q, cnt_err_d;
  logic         fail_q;

  always_comb begin
    deg_d = '0;
    for (int i = 1; i <= T; i++)
      if (sigma_i[M*i +: M] != '0) deg_d = M'(i);
  end

  assign cnt_err_d = (e && cnt_err_q != '1) ? cnt_err_q + 1'b1 : cnt_err_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      deg_q     <= '0;
      cnt_err_q <= '0;
      fail_q    <= 1'b0;
    end else if (accept) begin
      deg_q     <= deg_d;
      cnt_err_q <= '0;
      fail_q    <= 1'b0;
    end else if (state_q == RUN) begin
      cnt_err_q <= cnt_err_d;
      if (cnt_q == LAST_CNT) fail_q <= (cnt_err_d != deg_q);
    end
  end

  assign err_count_o = cnt_err_q;
  assign fail_o      = fail_q;
`else
  assign err_count_o = '0;
  assign fail_o      = 1'b0;
`endif

endmodule

// File: tb/tb_chien_search_serial.sv
// Scoreboard bench for chien_search_serial (M=4, T=3, x^4+x+1); expected streams are hand-derived.
module tb_chien_search_serial;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sigma;
  logic        sigma_valid;
  logic        ready, err, err_valid, err_first, err_last, fail;
  logic [3:0]  err_count;

  chien_search_serial #(.M(4), .T(3)) dut (
    .clk_i(clk), .reset_i(reset), .sigma_i(sigma), .sigma_valid_i(sigma_valid),
    .ready_o(ready), .err_o(err), .err_valid_o(err_valid), .err_first_o(err_first),
    .err_last_o(err_last), .err_count_o(err_count), .fail_o(fail)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       err;
    logic       first;
    logic       last;
    logic [3:0] cnt;
    logic       fail;
    int         first_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: every qualified output cycle is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (err_valid) begin
      if (sb.size() == 0) begin
        check("stray_err_valid", {31'd0, err_valid}, 32'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("err", {31'd0, err}, {31'd0, x.err});
        check("err_first", {31'd0, err_first}, {31'd0, x.first});
        check("err_last", {31'd0, err_last}, {31'd0, x.last});
        if (x.first) check("first_cycle", cyc, x.first_cyc);
        if (x.last) begin
          check("err_count", {28'd0, err_count}, {28'd0, x.cnt});
          check("fail", {31'd0, fail}, {31'd0, x.fail});
          check("ready_on_last", {31'd0, ready}, 32'd1);
          $display("stream done: count=%0d fail=%0d", err_count, fail);
        end
      end
    end
  end

  task automatic send(input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] s3,
                      input logic [14:0] mask, input logic [3:0] cnt, input logic f);
    int   guard;
    int   c;
    exp_t x;
    guard = 0;
    @(negedge clk);
    while (!ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("ready_wait", {31'd0, ready}, 32'd1);
    sigma       = {s3, s2, s1, 4'h1};
    sigma_valid = 1'b1;
    c = cyc;
    $display("accept sigma=%h at cycle %0d", {s3, s2, s1, 4'h1}, c);
    for (int k = 0; k < 15; k++) begin
      x.err       = mask[k];
      x.first     = (k == 0);
      x.last      = (k == 14);
`ifdef CHIEN_ERRCNT_EN
      x.cnt       = cnt;
      x.fail      = f;
`else
      x.cnt       = 4'd0;
      x.fail      = 1'b0;
`endif
      x.first_cyc = c + 2;
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    sigma_valid = 1'b0;
    sigma       = 16'hFFFF;   // must not disturb the captured polynomial
    @(negedge clk);
    check("ready_fall", {31'd0, ready}, 32'd0);
  endtask

  task automatic drain;
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    check("drained", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset       = 1'b1;
    sigma       = '0;
    sigma_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_err_valid", {31'd0, err_valid}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_first_last", {30'd0, err_first, err_last}, 32'd0);
    check("rst_count", {28'd0, err_count}, 32'd0);
    check("rst_fail", {31'd0, fail}, 32'd0);

    // Reset and sigma_valid together: reset wins, no stream.
    sigma       = {4'h0, 4'h0, 4'hB, 4'h1};
    sigma_valid = 1'b1;
    @(posedge clk);
    #1;
    reset       = 1'b0;
    sigma_valid = 1'b0;
    @(negedge clk);
    check("rst_wins_ready", {31'd0, ready}, 32'd1);
    repeat (5) @(negedge clk);

    // Cases 1..4, back to back through the ready handshake.
    send(4'h0, 4'h0, 4'h0, 15'h0000, 4'd0, 1'b0);
    send(4'hB, 4'h0, 4'h0, 15'h0080, 4'd1, 1'b0);
    send(4'h8, 4'h9, 4'h0, 15'h4001, 4'd2, 1'b0);
    send(4'h0, 4'h1, 4'h0, 15'h4000, 4'd1, 1'b1);
    drain();

    // Case 5: stray sigma_valid at c+5 ignored, then accept on the err_last cycle.
    send(4'hB, 4'h0, 4'h0, 15'h0080, 4'd1, 1'b0);
    repeat (4) @(negedge clk);
    sigma       = {4'h0, 4'h9, 4'h8, 4'h1};
    sigma_valid = 1'b1;
    @(posedge clk);
    #1;
    sigma_valid = 1'b0;
    send(4'h8, 4'h9, 4'h0, 15'h4001, 4'd2, 1'b0);
    drain();

    // Case 6: reset during RUN at c+7 aborts the stream.
    send(4'h0, 4'h1, 4'h0, 15'h4000, 4'd1, 1'b1);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_err_valid", {31'd0, err_valid}, 32'd0);
    check("abort_err_last", {31'd0, err_last}, 32'd0);
    check("abort_count", {28'd0, err_count}, 32'd0);
    check("abort_fail", {31'd0, fail}, 32'd0);
    repeat (20) @(negedge clk);

    // Recovery after the abort.
    send(4'h8, 4'h9, 4'h0, 15'h4001, 4'd2, 1'b0);
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
